role_axil_ctrl_slave: RTL
=========================

Name: role_axil_ctrl_slave

Overview:
AXI4-Lite responder inside the role_NORTH partial-reconfiguration region. It terminates the shell's AXI-Lite master (the S_AXI_LITE_FROM_STATIC link) and exposes a small kernel control/status register file. It drives ap_start to the HLS kernel, captures ap_done and the kernel's ker_count result, and raises an interrupt level back toward the shell.

Parameters:
ADDR_W, 12, AXI-Lite address width (byte address); only bits [4:2] are decoded, upper bits must be zero for a hit.
DATA_W, 32, AXI-Lite data width; fixed at 32, other values are unsupported.
VERSION, 32'h0001_0000, value returned by the VERSION register.

Ports:
CLK_IN_250  in  1  sole clock; all logic is in this domain.
AXI_RESET_N  in  1  synchronous, active-low reset.
s_axil_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel.
s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
s_axil_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel.
s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
ap_start  out  1  kernel start, HLS level protocol.
ap_ready  in  1  kernel has consumed its start.
ap_done  in  1  one-cycle completion pulse.
ap_idle  in  1  kernel idle level.
ker_count  in  32  kernel result.
ker_count_ap_vld  in  1  qualifies ker_count.
irq  out  1  level interrupt = done_sticky & IER.

Behaviour:
- Register map:
  - 0x00 CTRL: bit0 START, write 1 only, reads back as ap_start; bit1 AUTO_RESTART, RW.
  - 0x04 STATUS: bit0 DONE, sticky, write 1 to clear; bit1 IDLE, read-only live ap_idle; bit2 CNT_VLD, sticky, write 1 to clear.
  - 0x08 KER_COUNT: read-only, captured value.
  - 0x0C IER: bit0, RW.
  - 0x10 SCRATCH: RW, byte strobes honoured.
  - 0x14 VERSION: read-only.
- Unmapped address: reads return 0 with RRESP=2'b10 (SLVERR); writes are dropped with BRESP=2'b10. Writes to read-only registers are ignored with OKAY.
- Reset values: all ready and valid outputs 0; bresp and rresp 0; rdata 0; ap_start 0; irq 0; all registers 0 except VERSION.
- Write path:
  - States W_IDLE, W_RESP.
  - In W_IDLE, awready is high until AW has been captured and wready is high until W has been captured; AW and W may arrive in either order or in the same cycle.
  - The register update happens in the cycle after both halves are held. In that same edge bvalid goes to 1 and the FSM enters W_RESP.
  - In W_RESP, awready and wready are 0; bvalid is held until bready, then the FSM returns to W_IDLE.
  - One write outstanding at most.
- Read path:
  - States R_IDLE, R_RESP.
  - arready=1 in R_IDLE. On an AR handshake, rdata and rresp are registered and rvalid=1 on the next cycle (1-cycle latency).
  - rdata and rresp are held stable until rready, then the FSM returns to R_IDLE.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Kernel handshake:
  - A CTRL.START=1 write sets ap_start when ap_start=0. While ap_start=1 the write is ignored.
  - ap_start clears on the cycle after ap_ready=1, unless AUTO_RESTART=1, in which case ap_start stays asserted.
- Captures:
  - ap_done=1 sets DONE.
  - ker_count_ap_vld=1 loads KER_COUNT and sets CNT_VLD.
  - If a set and a W1C land in the same cycle, the set wins.
- irq is registered, so it lags DONE by 1 cycle.
- Reset mid-transaction: both FSMs go to IDLE and valids drop the same edge; the kernel side sees ap_start=0 the cycle after reset is sampled.

Decomposition:
- Package role_ctrl_pkg holds:
  - register offset localparams;
  - CTRL/STATUS bit index constants;
  - RESP_OKAY and RESP_SLVERR;
  - FSM state enums w_state_t and r_state_t.
- One natural sub-module, role_ctrl_regfile: the register storage, capture logic and read mux. The top keeps the two AXI-Lite channel FSMs.

Test Plan:
1. Reset → all outputs 0; read 0x14 → rdata=32'h0001_0000, rresp=0, rvalid exactly 1 cycle after the AR handshake.
2. AW issued 3 cycles before W, write 0x10=32'hDEADBEEF with wstrb=4'b0101 → read 0x10 returns 32'h00AD00EF; bvalid is held through 5 cycles of bready=0.
3. Write CTRL=1 → ap_start=1; ap_ready pulse → ap_start=0 next cycle; ap_done pulse with ker_count=32'd1234 and ker_count_ap_vld → STATUS[0]=1, STATUS[2]=1, KER_COUNT=1234; with IER=1, irq=1 one cycle after DONE.
4. W1C STATUS=1 in the same cycle as an ap_done pulse → DONE remains 1; a second W1C → DONE=0 and irq drops.
5. Read of 0x18 → rdata=0, rresp=2'b10; write of 0x1C → bresp=2'b10 and no register changes.
6. Assert AXI_RESET_N=0 while bvalid=1 and ap_start=1 → bvalid, ap_start and irq are 0 after the reset edge; a new write completes normally after reset is released.

Source files
------------

// File: rtl/role_ctrl_pkg.sv
// Shared constants and FSM state types for the role_NORTH AXI-Lite kernel control block.
package role_ctrl_pkg;

    localparam logic [4:0] OFF_CTRL      = 5'h00;
    localparam logic [4:0] OFF_STATUS    = 5'h04;
    localparam logic [4:0] OFF_KER_COUNT = 5'h08;
    localparam logic [4:0] OFF_IER       = 5'h0C;
    localparam logic [4:0] OFF_SCRATCH   = 5'h10;
    localparam logic [4:0] OFF_VERSION   = 5'h14;

    localparam int CTRL_START        = 0;
    localparam int CTRL_AUTO_RESTART = 1;
    localparam int STAT_DONE         = 0;
    localparam int STAT_IDLE         = 1;
    localparam int STAT_CNT_VLD      = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    // Word index [4:2] lands on a real register (VERSION is the last one).
    function automatic logic reg_mapped(input logic [2:0] idx);
        return {idx, 2'b00} <= OFF_VERSION;
    endfunction

endpackage

// File: rtl/role_ctrl_regfile.sv
// Kernel control/status register storage, ap_start handshake, done/count capture and read mux.
module role_ctrl_regfile
    import role_ctrl_pkg::*;
#(
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic [2:0]  rd_idx,
    output logic [31:0] rd_data,
    output logic        ap_start,
    input  logic        ap_ready,
    input  logic        ap_done,
    input  logic        ap_idle,
    input  logic [31:0] ker_count,
    input  logic        ker_count_ap_vld,
    output logic        irq
);

    logic        ap_start_q, ap_start_d;
    logic        auto_restart_q, auto_restart_d;
    logic        done_q, done_d;
    logic        cnt_vld_q, cnt_vld_d;
    logic [31:0] ker_count_q, ker_count_d;
    logic        ier_q, ier_d;
    logic [31:0] scratch_q, scratch_d;
    logic        irq_q, irq_d;

    logic wr_ctrl, wr_status, wr_ier, wr_scratch;

    always_comb begin
        wr_ctrl    = wr_en && ({wr_idx, 2'b00} == OFF_CTRL);
        wr_status  = wr_en && ({wr_idx, 2'b00} == OFF_STATUS);
        wr_ier     = wr_en && ({wr_idx, 2'b00} == OFF_IER);
        wr_scratch = wr_en && ({wr_idx, 2'b00} == OFF_SCRATCH);

        ap_start_d = ap_start_q;
        if (ap_start_q) begin
            if (ap_ready && !auto_restart_q) ap_start_d = 1'b0;
        end else if (wr_ctrl && wr_data[CTRL_START]) begin
            ap_start_d = 1'b1;
        end
        auto_restart_d = wr_ctrl ? wr_data[CTRL_AUTO_RESTART] : auto_restart_q;

        // Clear first so a same-cycle kernel event overrides the W1C.
        done_d = done_q;
        if (wr_status && wr_data[STAT_DONE]) done_d = 1'b0;
        if (ap_done) done_d = 1'b1;
        cnt_vld_d = cnt_vld_q;
        if (wr_status && wr_data[STAT_CNT_VLD]) cnt_vld_d = 1'b0;
        if (ker_count_ap_vld) cnt_vld_d = 1'b1;
        ker_count_d = ker_count_ap_vld ? ker_count : ker_count_q;

        ier_d = wr_ier ? wr_data[0] : ier_q;
        scratch_d = scratch_q;
        for (int b = 0; b < 4; b++)
            if (wr_scratch && wr_strb[b]) scratch_d[8*b +: 8] = wr_data[8*b +: 8];

        irq_d = done_q & ier_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ap_start_q     <= 1'b0;
            auto_restart_q <= 1'b0;
            done_q         <= 1'b0;
            cnt_vld_q      <= 1'b0;
            ker_count_q    <= '0;
            ier_q          <= 1'b0;
            scratch_q      <= '0;
            irq_q          <= 1'b0;
        end else begin
            ap_start_q     <= ap_start_d;
            auto_restart_q <= auto_restart_d;
            done_q         <= done_d;
            cnt_vld_q      <= cnt_vld_d;
            ker_count_q    <= ker_count_d;
            ier_q          <= ier_d;
            scratch_q      <= scratch_d;
            irq_q          <= irq_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case ({rd_idx, 2'b00})
            OFF_CTRL:      rd_data = {30'd0, auto_restart_q, ap_start_q};
            OFF_STATUS:    rd_data = {29'd0, cnt_vld_q, ap_idle, done_q};
            OFF_KER_COUNT: rd_data = ker_count_q;
            OFF_IER:       rd_data = {31'd0, ier_q};
            OFF_SCRATCH:   rd_data = scratch_q;
            OFF_VERSION:   rd_data = VERSION;
            default:       rd_data = '0;
        endcase
    end

    assign ap_start = ap_start_q;
    assign irq      = irq_q;

endmodule

// File: rtl/role_axil_ctrl_slave.sv
// AXI4-Lite responder for the role_NORTH kernel control registers: write and read channel FSMs.
module role_axil_ctrl_slave
    import role_ctrl_pkg::*;
#(
    parameter int          ADDR_W  = 12,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic                CLK_IN_250,
    input  logic                AXI_RESET_N,
    input  logic [ADDR_W-1:0]   s_axil_awaddr,
    input  logic                s_axil_awvalid,
    output logic                s_axil_awready,
    input  logic [DATA_W-1:0]   s_axil_wdata,
    input  logic [DATA_W/8-1:0] s_axil_wstrb,
    input  logic                s_axil_wvalid,
    output logic                s_axil_wready,
    output logic [1:0]          s_axil_bresp,
    output logic                s_axil_bvalid,
    input  logic                s_axil_bready,
    input  logic [ADDR_W-1:0]   s_axil_araddr,
    input  logic                s_axil_arvalid,
    output logic                s_axil_arready,
    output logic [DATA_W-1:0]   s_axil_rdata,
    output logic [1:0]          s_axil_rresp,
    output logic                s_axil_rvalid,
    input  logic                s_axil_rready,
    output logic                ap_start,
    input  logic                ap_ready,
    input  logic                ap_done,
    input  logic                ap_idle,
    input  logic [31:0]         ker_count,
    input  logic                ker_count_ap_vld,
    output logic                irq
);

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        return (a[ADDR_W-1:5] == '0) && reg_mapped(a[4:2]);
    endfunction

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    w_state_t            w_state_q, w_state_d;
    r_state_t            r_state_q, r_state_d;
    logic                alive_q;
    logic                aw_held_q, aw_held_d;
    logic                w_held_q, w_held_d;
    logic                w_hit_q, w_hit_d;
    logic [2:0]          w_idx_q, w_idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic              wr_en;
    logic [DATA_W-1:0] reg_rdata;
    logic              r_hit;

    // Readies stay low through reset and the first cycle after it.
    assign s_axil_awready = alive_q && (w_state_q == W_IDLE) && !aw_held_q;
    assign s_axil_wready  = alive_q && (w_state_q == W_IDLE) && !w_held_q;
    assign s_axil_arready = alive_q && (r_state_q == R_IDLE);
    assign r_hit          = addr_hit(s_axil_araddr);

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        w_hit_d   = w_hit_q;
        w_idx_d   = w_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axil_awvalid && s_axil_awready) begin
                    aw_held_d = 1'b1;
                    w_hit_d   = addr_hit(s_axil_awaddr);
                    w_idx_d   = s_axil_awaddr[4:2];
                end
                if (s_axil_wvalid && s_axil_wready) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axil_wdata;
                    wstrb_d  = s_axil_wstrb;
                end
                if (aw_held_q && w_held_q) begin
                    wr_en     = w_hit_q;
                    bresp_d   = w_hit_q ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axil_arvalid && s_axil_arready) begin
                    rdata_d   = r_hit ? reg_rdata : '0;
                    rresp_d   = r_hit ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axil_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN_250) begin
        if (!AXI_RESET_N) begin
            alive_q   <= 1'b0;
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            w_hit_q   <= 1'b0;
            w_idx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            alive_q   <= 1'b1;
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            w_hit_q   <= w_hit_d;
            w_idx_q   <= w_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rdata  = rdata_q;

    role_ctrl_regfile #(.VERSION(VERSION)) u_regfile (
        .clk              (CLK_IN_250),
        .rst_n            (AXI_RESET_N),
        .wr_en            (wr_en),
        .wr_idx           (w_idx_q),
        .wr_data          (wdata_q),
        .wr_strb          (wstrb_q),
        .rd_idx           (s_axil_araddr[4:2]),
        .rd_data          (reg_rdata),
        .ap_start         (ap_start),
        .ap_ready         (ap_ready),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ker_count        (ker_count),
        .ker_count_ap_vld (ker_count_ap_vld),
        .irq              (irq)
    );

endmodule
